// File: rtl/first_down_counter.sv
// Purpose : loadable down-counter/timer with terminal-count pulse, optional auto-reload, sticky underflow.
// Latency : 1 cycle from sampled load/enable to counter_out; done_pulse/underflow_out rise on the expiry edge.
// Backpr. : none; enable is a per-cycle request that is ignored outside RUN.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   load            capture load_value into counter and reload register (highest priority)
//   load_value      start / reload value; zero parks the block in IDLE
//   enable          decrement request, one count per cycle while in RUN
//   auto_reload     on expiry restart from the reload register instead of stopping
//   clear_underflow clear the sticky underflow flag (a simultaneous expiry wins)
//   counter_out     current count
//   done_pulse      one-cycle pulse following each expiry
//   underflow_out   sticky expiry flag
//   busy            high while in RUN
module first_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic             clear_underflow,
  output logic [WIDTH-1:0] counter_out,
  output logic             done_pulse,
  output logic             underflow_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;

  state_t           state;
  logic [WIDTH-1:0] reload_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      counter_out   <= '0;
      reload_reg    <= '0;
      done_pulse    <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
      done_pulse <= 1'b0;

      // Clear is evaluated first so that an expiry on the same edge,
      // assigned further down, leaves the flag set.
      if (clear_underflow) begin
        underflow_out <= 1'b0;
      end

      if (load) begin
        counter_out <= load_value;
        reload_reg  <= load_value;
        // A zero start value has nothing to count; park in IDLE.
        state       <= (load_value != CNT_ZERO) ? RUN : IDLE;
      end else begin
        case (state)
          RUN: begin
            if (enable) begin
              if (counter_out == CNT_ONE) begin
                done_pulse    <= 1'b1;
                underflow_out <= 1'b1;
                if (auto_reload) begin
                  // reload_reg is non-zero here: RUN is only entered
                  // through a load of a non-zero value.
                  counter_out <= reload_reg;
                end else begin
                  counter_out <= CNT_ZERO;
                  state       <= EXPIRED;
                end
              end else if (counter_out > CNT_ONE) begin
                counter_out <= counter_out - CNT_ONE;
              end
            end
          end
          // IDLE and EXPIRED hold until the next load; no wrap below 0.
          default: begin
            counter_out <= counter_out;
          end
        endcase
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_first_down_counter.sv
// Directed bench for first_down_counter: hand-computed expectations per step,
// plus a reference timer model compared against the DUT every cycle.
module tb_first_down_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         enable = 1'b0;
  logic         auto_reload = 1'b0;
  logic         clear_underflow = 1'b0;
  logic [W-1:0] counter_out;
  logic         done_pulse;
  logic         underflow_out;
  logic         busy;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  first_down_counter #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .load            (load),
    .load_value      (load_value),
    .enable          (enable),
    .auto_reload     (auto_reload),
    .clear_underflow (clear_underflow),
    .counter_out     (counter_out),
    .done_pulse      (done_pulse),
    .underflow_out   (underflow_out),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference timer: "remaining" is the number of enabled cycles left
  // before the timer fires; "running" is true while counting.
  int m_remaining = 0;
  int m_period    = 0;
  bit m_running   = 1'b0;
  bit m_done      = 1'b0;
  bit m_flag      = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_remaining = 0;
      m_period    = 0;
      m_running   = 1'b0;
      m_done      = 1'b0;
      m_flag      = 1'b0;
    end else begin
      m_done = 1'b0;
      if (clear_underflow) m_flag = 1'b0;
      if (load) begin
        m_period    = int'(load_value);
        m_remaining = m_period;
        m_running   = (m_period > 0);
      end else if (m_running && enable) begin
        m_remaining = m_remaining - 1;
        if (m_remaining == 0) begin
          m_done = 1'b1;
          m_flag = 1'b1;
          if (auto_reload) m_remaining = m_period;
          else m_running = 1'b0;
        end
      end
    end
    #1;
    if (check_en) begin
      chk("cyc_counter", 32'(counter_out), 32'(m_remaining));
      chk("cyc_done", 32'(done_pulse), 32'(m_done));
      chk("cyc_underflow", 32'(underflow_out), 32'(m_flag));
      chk("cyc_busy", 32'(busy), 32'(m_running));
    end
  end

  task automatic drive(input bit ld, input int lv, input bit en, input bit ar, input bit clr);
    load            = ld;
    load_value      = W'(lv);
    enable          = en;
    auto_reload     = ar;
    clear_underflow = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    int last_pulse;
    int en_pat[4];
    int exp_pat[4];

    // Reset state
    tick();
    tick();
    chk("rst_counter", 32'(counter_out), 0);
    chk("rst_done", 32'(done_pulse), 0);
    chk("rst_underflow", 32'(underflow_out), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    check_en = 1'b1;
    tick();

    // Basic countdown from 5; enable during the load cycle is ignored
    drive(1, 5, 1, 0, 0);
    tick();
    chk("basic_load", 32'(counter_out), 5);
    chk("basic_busy", 32'(busy), 1);
    chk("model_pin_load", 32'(m_remaining), 5);
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("basic_count", 32'(counter_out), 32'(4 - i));
      chk("basic_done", 32'(done_pulse), (i == 4) ? 1 : 0);
      chk("basic_busy_run", 32'(busy), (i == 4) ? 0 : 1);
    end
    chk("basic_flag", 32'(underflow_out), 1);
    chk("model_pin_expired", 32'(m_running), 0);
    tick();
    chk("expired_hold", 32'(counter_out), 0);
    chk("expired_done_low", 32'(done_pulse), 0);

    // Sticky flag clear
    drive(0, 0, 0, 0, 1);
    tick();
    chk("sticky_clear", 32'(underflow_out), 0);

    // Auto-reload with period 3 over 12 enabled cycles
    drive(1, 3, 0, 1, 0);
    tick();
    chk("ar_load", 32'(counter_out), 3);
    drive(0, 0, 1, 1, 0);
    pulses = 0;
    last_pulse = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("ar_count", 32'(counter_out), (k % 3 == 0) ? 3 : 32'(3 - (k % 3)));
      if (done_pulse) begin
        pulses++;
        chk("ar_spacing", 32'(k - last_pulse), 3);
        last_pulse = k;
      end
      if (k >= 3) chk("ar_flag", 32'(underflow_out), 1);
    end
    chk("ar_pulses", 32'(pulses), 4);

    // Clear on the expiry cycle: set wins
    tick();
    tick();
    chk("ar_pre_expiry", 32'(counter_out), 1);
    drive(0, 0, 1, 1, 1);
    tick();
    chk("set_wins_flag", 32'(underflow_out), 1);
    chk("set_wins_done", 32'(done_pulse), 1);
    chk("set_wins_reload", 32'(counter_out), 3);

    // Load beats a would-be expiry
    drive(1, 2, 0, 0, 1);
    tick();
    chk("prio_load2", 32'(counter_out), 2);
    chk("prio_flag_cleared", 32'(underflow_out), 0);
    drive(0, 0, 1, 0, 0);
    tick();
    chk("prio_at_one", 32'(counter_out), 1);
    drive(1, 9, 1, 0, 0);
    tick();
    chk("prio_counter", 32'(counter_out), 9);
    chk("prio_done", 32'(done_pulse), 0);
    chk("prio_flag", 32'(underflow_out), 0);
    chk("prio_busy", 32'(busy), 1);

    // Zero load parks in IDLE
    drive(1, 0, 1, 0, 0);
    tick();
    chk("zero_counter", 32'(counter_out), 0);
    chk("zero_busy", 32'(busy), 0);
    drive(0, 0, 1, 0, 0);
    repeat (3) tick();
    chk("idle_counter", 32'(counter_out), 0);
    chk("idle_done", 32'(done_pulse), 0);
    chk("idle_busy", 32'(busy), 0);

    // Max value with gapped enable
    drive(1, 15, 0, 0, 0);
    tick();
    chk("max_load", 32'(counter_out), 15);
    en_pat  = '{1, 0, 1, 0};
    exp_pat = '{14, 14, 13, 13};
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, en_pat[i][0], 0, 0);
      tick();
      chk("gap_count", 32'(counter_out), 32'(exp_pat[i]));
    end

    // Expire with period 1, then load does not clear the flag
    drive(1, 1, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    tick();
    chk("p1_done", 32'(done_pulse), 1);
    chk("p1_counter", 32'(counter_out), 0);
    chk("p1_busy", 32'(busy), 0);
    drive(1, 7, 1, 0, 0);
    tick();
    chk("load7_counter", 32'(counter_out), 7);
    chk("load_keeps_flag", 32'(underflow_out), 1);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("hold7", 32'(counter_out), 7);

    // Asynchronous reset between clock edges
    #2;
    reset = 1'b0;
    #1;
    chk("arst_counter", 32'(counter_out), 0);
    chk("arst_flag", 32'(underflow_out), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done_pulse), 0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 1, 0, 0);
    tick();
    tick();
    chk("post_rst_counter", 32'(counter_out), 0);
    chk("post_rst_busy", 32'(busy), 0);
    drive(1, 4, 0, 0, 0);
    tick();
    chk("post_rst_load", 32'(counter_out), 4);
    chk("post_rst_busy_run", 32'(busy), 1);

    drive(0, 0, 0, 0, 0);
    tick();
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/first_down_counter.md
# first_down_counter

Loadable 4-bit (parameterisable) down-counter/timer with terminal-count detection, optional auto-reload and a sticky underflow flag. It is the counting-down counterpart of the team's up-counter with overflow. It is intended as a programmable interval/timeout source beside the up-counters in the same clock domain. Software-style control (load, enable, clear) drives it, and a one-cycle `done_pulse` plus a level `underflow_out` report expiry.

## Interface
- `WIDTH`, 4, counter width in bits (≥2).
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset (0 = reset asserted).
- `load`  input  1  load `load_value` into counter and reload register.
- `load_value`  input  WIDTH  start/reload value.
- `enable`  input  1  decrement request (one count per cycle while high).
- `auto_reload`  input  1  on expiry, reload from reload register instead of stopping.
- `clear_underflow`  input  1  clears sticky `underflow_out`.
- `counter_out`  output  WIDTH  current count.
- `done_pulse`  output  1  high for exactly one cycle after each expiry.
- `underflow_out`  output  1  sticky expiry flag.
- `busy`  output  1  high while in RUN.

## Operation
- Registers: `counter_out`, `reload_reg` (WIDTH), `state` (IDLE, RUN, EXPIRED), `done_pulse`, `underflow_out`. All outputs are registered; `busy` = (state==RUN) decoded from the state register.
- Reset (`reset`=0, asynchronous): `counter_out`=0, `reload_reg`=0, `done_pulse`=0, `underflow_out`=0, state=IDLE, `busy`=0. Reset takes effect immediately, mid-count included. Release is synchronous to the next rising edge.
- Priority per edge: `load` > expiry/decrement. `clear_underflow` is evaluated independently.
- `load`=1, any state:
  - `counter_out`←`load_value` and `reload_reg`←`load_value`.
  - If `load_value`≠0, state←RUN; otherwise state←IDLE.
  - `enable` is ignored that cycle, and no `done_pulse` is produced.
- RUN, `enable`=1, `counter_out`>1: `counter_out`←`counter_out`−1.
- RUN, `enable`=1, `counter_out`==1 (expiry): `done_pulse`←1 and `underflow_out`←1.
  - If `auto_reload`=1: `counter_out`←`reload_reg` and state stays RUN.
  - If `auto_reload`=0: `counter_out`←0 and state←EXPIRED.
- RUN, `enable`=0: hold all values.
- IDLE and EXPIRED: `enable` is ignored, the counter holds and never wraps below 0. Only `load` leaves these states.
- `done_pulse` is 0 in every cycle not directly following an expiry edge.
- `underflow_out`:
  - Set on every expiry.
  - Cleared by `clear_underflow`=1 only.
  - Simultaneous expiry and clear leaves it set (set wins).
  - It is not cleared by `load`.
- Arithmetic is unsigned modulo 2^WIDTH. A reload value of 2^WIDTH−1 gives a period of 2^WIDTH−1 enabled cycles. Reload value N gives expiry every N enabled cycles.

## Timing
- All state and output changes happen on the rising `clk` edge, except reset.
- Load latency: `counter_out` shows `load_value` one cycle after `load` is sampled.
- Decrement latency: 1 cycle per sampled `enable`.
- Expiry: `done_pulse` and `underflow_out` rise on the same edge that `counter_out` goes 1→0 (or 1→reload).
- Expiry timing from load (`enable` held high continuously, load value N): `done_pulse` is high in cycle N after the load cycle.
- With auto-reload, `done_pulse` repeats every N cycles with no gap cycle.
- `load` in the same cycle as a would-be expiry: load wins; no pulse and no flag set.
- `load` during RUN restarts the count immediately.

## Test plan
- Basic countdown: reset, then `load`=1 with `load_value`=5, then `enable` held high.
  - `counter_out` reads 5,4,3,2,1,0.
  - `done_pulse` is high for exactly one cycle as the counter reaches 0, then the block is in EXPIRED.
  - `busy` goes 1→0 on that cycle, and further `enable` keeps the counter at 0.
- Auto-reload: `load_value`=3 with `auto_reload`=1 and `enable` held high for 12 cycles.
  - Count sequence is 3,2,1,3,2,1,…
  - `done_pulse` is seen 4 times, spaced 3 cycles apart.
  - `underflow_out` stays 1.
- Sticky flag: after an expiry, pulse `clear_underflow` → `underflow_out`=0 next cycle. Then assert `clear_underflow` on the expiry cycle itself → `underflow_out` remains 1.
- Load priority: `load_value`=2, count down to 1, then assert `load`=1 (`load_value`=9) together with `enable`.
  - Next cycle: `counter_out`=9, `done_pulse`=0, state RUN.
- Zero load and gaps: `load_value`=0 → state IDLE and `busy`=0; `enable` does nothing.
  - Then `load_value`=15 with `enable` toggling 1,0,1,0 → count is 15,14,14,13,13.
- Async reset mid-run: assert `reset`=0 between clock edges while `counter_out`=7.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, the block stays in IDLE until the next `load`.
